// File: rtl/rv32_fxdiv_unit_pkg.sv
// Shared types and constants for the rv32 fixed-point divider.
package rv32_types;

  typedef logic [31:0] rv32_word;

  typedef enum logic [1:0] {
    FXDIV_IDLE,
    FXDIV_CALC,
    FXDIV_DONE
  } fxdiv_state_t;

  localparam rv32_word FXDIV_DIV0_RESULT = 32'hFFFF_FFFF;
  localparam int unsigned FXDIV_SCALE_W = 5;

  // Unsigned magnitude; -2^31 maps to 32'h8000_0000 which reads back as 2^31.
  function automatic rv32_word fxdiv_abs(input rv32_word v);
    return v[31] ? rv32_word'(-v) : v;
  endfunction

endpackage

// File: rtl/rv32_fxdiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, conditionally subtract.
module rv32_fxdiv_step (
  input  logic [32:0] rem_i,
  input  logic        bit_i,
  input  logic [31:0] divisor_i,
  output logic [32:0] rem_next_o,
  output logic        qbit_o
);

  logic [33:0] shifted;
  logic [32:0] diff;

  assign shifted    = {rem_i, bit_i};
  assign qbit_o     = (shifted >= {2'b00, divisor_i});
  assign diff       = shifted[32:0] - {1'b0, divisor_i};
  assign rem_next_o = qbit_o ? diff : shifted[32:0];

endmodule

// File: rtl/rv32_fxdiv_unit.sv
// Iterative signed fixed-point divider: trunc((dividend << scale) / divisor), low 32 bits.
module rv32_fxdiv_unit
  import rv32_types::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic [2:0] low_bits_selected_scale,
  input  logic [1:0] high_bit_selected_scale,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [31:0] result
);

  localparam int unsigned N = 64 / STEPS_PER_CYCLE;

  fxdiv_state_t state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [63:0]  dq_q, dq_d;
  logic [32:0]  rem_q, rem_d;
  rv32_word     dvs_q, dvs_d;
  logic         qsign_q, qsign_d;
  rv32_word     result_q, result_d;

  logic [FXDIV_SCALE_W-1:0]   scale;
  logic [32:0]                rem_chain [STEPS_PER_CYCLE+1];
  logic [STEPS_PER_CYCLE-1:0] qbits;
  logic [63:0]                dq_next;
  rv32_word                   q_signed;

  assign scale = {high_bit_selected_scale, low_bits_selected_scale};

  // dq_q holds the shifted dividend in its upper bits while quotient bits enter at the bottom.
  assign rem_chain[0] = rem_q;
  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
    rv32_fxdiv_step u_step (
      .rem_i      (rem_chain[k]),
      .bit_i      (dq_q[63-k]),
      .divisor_i  (dvs_q),
      .rem_next_o (rem_chain[k+1]),
      .qbit_o     (qbits[STEPS_PER_CYCLE-1-k])
    );
  end

  assign dq_next  = {dq_q[63-STEPS_PER_CYCLE:0], qbits};
  assign q_signed = qsign_q ? rv32_word'(-dq_next[31:0]) : dq_next[31:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    qsign_d  = qsign_q;
    result_d = result_q;
    if (flush) begin
      state_d = FXDIV_IDLE;
    end else begin
      unique case (state_q)
        FXDIV_IDLE: begin
          if (in_valid) begin
            qsign_d = dividend[31] ^ divisor[31];
            dq_d    = 64'(fxdiv_abs(dividend)) << scale;
            dvs_d   = fxdiv_abs(divisor);
            rem_d   = '0;
            cnt_d   = 6'(N - 1);
            if (divisor == '0) begin
              result_d = FXDIV_DIV0_RESULT;
              state_d  = FXDIV_DONE;
            end else begin
              state_d  = FXDIV_CALC;
            end
          end
        end
        FXDIV_CALC: begin
          dq_d  = dq_next;
          rem_d = rem_chain[STEPS_PER_CYCLE];
          if (cnt_q == '0) begin
            result_d = q_signed;
            state_d  = FXDIV_DONE;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
        FXDIV_DONE: begin
          if (out_ready) state_d = FXDIV_IDLE;
        end
        default: state_d = FXDIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FXDIV_IDLE;
      cnt_q    <= '0;
      dq_q     <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      qsign_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      qsign_q  <= qsign_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == FXDIV_IDLE);
  assign out_valid = (state_q == FXDIV_DONE);
  assign result    = result_q;

endmodule
